// File: rtl/norm_cdf_pipe.sv
// Four-stage streaming standard-normal CDF with tag pass-through and global-advance flow control.
// The interpolation table is computed at elaboration: entry k = round(Phi(k*2^-STEP_LOG2)*2^FRAC).
module norm_cdf_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int STEP_LOG2 = 4,
  parameter int XMAX_INT  = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_n,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int FW    = FRAC - STEP_LOG2;
  localparam int AW    = FRAC + $clog2(XMAX_INT);
  localparam int IDX_W = AW - FW;
  localparam int LUT_N = (1 << IDX_W) + 1;
  localparam longint PHI_C = 64'sd1713444047;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
  localparam logic [WIDTH-1:0] XLIM = WIDTH'(XMAX_INT) << FRAC;

  // Phi(x) = 1/2 + phi(0) * sum (-1)^n x^(2n+1) / (2^n n! (2n+1)), evaluated in 2^-40 fixed point.
  function automatic logic [WIDTH-1:0] phiEntry(input int k);
    longint kk, p, s, n, v;
    kk = longint'(k);
    p  = kk <<< (40 - STEP_LOG2);
    s  = p;
    n  = 1;
    while (p != 0 && n < 200) begin
      p = ((p * kk) >>> STEP_LOG2) * kk / (n <<< (STEP_LOG2 + 1));
      if (n[0]) s = s - p / (2 * n + 1);
      else      s = s + p / (2 * n + 1);
      n = n + 1;
    end
    v = s * (PHI_C >>> 16) + ((s * (PHI_C & 64'sh0000_FFFF)) >>> 16);
    return WIDTH'((64'sd1 <<< (FRAC - 1)) + ((v + (64'sd1 <<< (55 - FRAC))) >>> (56 - FRAC)));
  endfunction

  logic [WIDTH-1:0] w_rom [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_rom
    localparam logic [WIDTH-1:0] ENTRY = phiEntry(k);
    assign w_rom[k] = ENTRY;
  end

  logic                    w_advance;
  logic                    w_xNeg;
  logic                    w_xMin;
  logic                    w_sat;
  logic [WIDTH-1:0]        w_absX;
  logic [IDX_W:0]          w_idxLo;
  logic [IDX_W:0]          w_idxHi;
  logic signed [WIDTH:0]   w_delta;
  logic signed [2*WIDTH-1:0] w_deltaExt;
  logic signed [2*WIDTH-1:0] w_fExt;
  logic signed [2*WIDTH-1:0] w_prod;

  logic             r_s0Valid, r_s0Sign, r_s0Sat;
  logic [AW-1:0]    r_s0A;
  logic [TAG_W-1:0] r_s0Tag;
  logic             r_s1Valid, r_s1Sign, r_s1Sat;
  logic [WIDTH-1:0] r_s1Lo, r_s1Hi;
  logic [FW-1:0]    r_s1F;
  logic [TAG_W-1:0] r_s1Tag;
  logic             r_s2Valid, r_s2Sign, r_s2Sat;
  logic [WIDTH-1:0] r_s2Y;
  logic [TAG_W-1:0] r_s2Tag;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outN;
  logic [TAG_W-1:0] r_outTag;

  assign w_advance = !r_outValid | out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_outValid;
  assign out_n     = r_outN;
  assign out_tag   = r_outTag;
  assign busy      = r_s0Valid | r_s1Valid | r_s2Valid | r_outValid;

  // The most-negative input has no positive twin, so it saturates without being negated.
  assign w_xNeg = in_x[WIDTH-1];
  assign w_xMin = w_xNeg & ~|in_x[WIDTH-2:0];
  assign w_absX = w_xNeg ? -in_x : in_x;
  assign w_sat  = w_xMin | (w_absX >= XLIM);

  assign w_idxLo    = {1'b0, r_s0A[AW-1:FW]};
  assign w_idxHi    = w_idxLo + (IDX_W + 1)'(1);
  assign w_delta    = $signed({1'b0, r_s1Hi}) - $signed({1'b0, r_s1Lo});
  assign w_deltaExt = {{(WIDTH - 1){w_delta[WIDTH]}}, w_delta};
  assign w_fExt     = {{(2 * WIDTH - FW){1'b0}}, r_s1F};
  assign w_prod     = w_deltaExt * w_fExt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0Valid  <= 1'b0;
      r_s1Valid  <= 1'b0;
      r_s2Valid  <= 1'b0;
      r_outValid <= 1'b0;
      r_outN     <= '0;
      r_outTag   <= '0;
    end else if (w_advance) begin
      r_s0Valid  <= in_valid;
      r_s1Valid  <= r_s0Valid;
      r_s2Valid  <= r_s1Valid;
      r_outValid <= r_s2Valid;
      r_outTag   <= r_s2Tag;
      if (r_s2Sat) r_outN <= r_s2Sign ? '0 : ONE;
      else         r_outN <= r_s2Sign ? ONE - r_s2Y : r_s2Y;
    end
  end

  // Datapath registers carry no reset; their valids decide whether they mean anything.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s0Sign <= w_xNeg;
      r_s0Sat  <= w_sat;
      r_s0A    <= w_absX[AW-1:0];
      r_s0Tag  <= in_tag;

      r_s1Sign <= r_s0Sign;
      r_s1Sat  <= r_s0Sat;
      r_s1Lo   <= w_rom[w_idxLo];
      r_s1Hi   <= w_rom[w_idxHi];
      r_s1F    <= r_s0A[FW-1:0];
      r_s1Tag  <= r_s0Tag;

      r_s2Sign <= r_s1Sign;
      r_s2Sat  <= r_s1Sat;
      r_s2Y    <= r_s1Lo + WIDTH'(w_prod >>> FW);
      r_s2Tag  <= r_s1Tag;
    end
  end

endmodule

// File: tb/tb_norm_cdf_pipe.sv
// Scoreboard bench for norm_cdf_pipe: directed vectors, random backpressure, mid-stream reset and a full sweep.
module tb_norm_cdf_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_n;
  logic [3:0]  out_tag;
  logic        busy;

  typedef struct {
    logic [31:0] n;
    logic [3:0]  tag;
    int          acceptEdge;
    bit          chkLat;
  } sbEntry_t;

  sbEntry_t sbQueue[$];
  int       sweepOut[$];
  int       lutRef[65];
  int       checkCount = 0;
  int       failCount  = 0;
  int       edgeCount  = 0;
  bit       randReady  = 1'b0;
  bit       captureOn  = 1'b0;

  norm_cdf_pipe #(
    .WIDTH(32), .FRAC(16), .STEP_LOG2(4), .XMAX_INT(4), .TAG_W(4)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .out_tag(out_tag),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); edgeCount++; end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic real phiRef(input real x);
    real t, s, x2;
    int  n;
    t = x; s = x; x2 = x * x; n = 1;
    while (n < 400) begin
      t = t * x2 / (2.0 * n);
      s = s + (((n % 2) == 1) ? -t : t) / (2.0 * n + 1.0);
      if (t < 1e-20 && t > -1e-20) break;
      n++;
    end
    return 0.5 + s * 0.3989422804014327;
  endfunction

  function automatic logic [31:0] modelN(input logic [31:0] x);
    longint xs, a, f, d, y;
    int     idx;
    bit     neg, sat;
    xs  = longint'($signed(x));
    neg = x[31];
    a   = neg ? -xs : xs;
    sat = (x == 32'h8000_0000) || (a >= 64'sd262144);
    if (sat) return neg ? 32'd0 : 32'd65536;
    idx = int'(a >>> 12);
    f   = a & 64'sd4095;
    d   = longint'(lutRef[idx + 1]) - longint'(lutRef[idx]);
    y   = longint'(lutRef[idx]) + ((d * f) >>> 12);
    return neg ? 32'(64'sd65536 - y) : 32'(y);
  endfunction

  task automatic applyStimulus(input logic [31:0] x, input logic [3:0] tag,
                               input logic [31:0] expN, input bit chkLat);
    int       waitCycles;
    sbEntry_t e;
    waitCycles = 0;
    in_valid = 1'b1; in_x = x; in_tag = tag;
    @(negedge clk);
    while (!in_ready && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    if (in_ready) begin
      e.n = expN; e.tag = tag; e.acceptEdge = edgeCount + 1; e.chkLat = chkLat;
      sbQueue.push_back(e);
    end else begin
      checkOutput("acceptTimeout", 64'(in_ready), 64'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (sbQueue.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(sbQueue.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Transfers are judged at the falling edge, where handshake signals are settled.
  initial begin
    sbEntry_t    e;
    bit          prevStall;
    logic [36:0] heldWord;
    prevStall = 1'b0;
    heldWord  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prevStall = 1'b0;
        continue;
      end
      if (prevStall) checkOutput("stallHold", 64'({out_valid, out_tag, out_n}), 64'(heldWord));
      if (out_valid && out_ready) begin
        if (sbQueue.size() == 0) begin
          checkOutput("spuriousOut", 64'd1, 64'd0);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("outN", 64'(out_n), 64'(e.n));
          checkOutput("outTag", 64'(out_tag), 64'(e.tag));
          if (e.chkLat) checkOutput("latency", 64'(edgeCount - e.acceptEdge + 1), 64'd4);
          if (captureOn) sweepOut.push_back(int'(out_n));
        end
      end
      prevStall = out_valid && !out_ready;
      heldWord  = {out_valid, out_tag, out_n};
    end
  end

  initial forever begin
    @(posedge clk); #2;
    if (randReady) out_ready = ($urandom_range(0, 99) < 55);
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checkCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rx;
    int          tolViol, monoViol, symViol;
    real         err, xr;

    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_tag = '0; out_ready = 1'b1;
    for (int k = 0; k < 65; k++) lutRef[k] = $rtoi(phiRef(k / 16.0) * 65536.0 + 0.5);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("rstOutValid", 64'(out_valid), 64'd0);
    checkOutput("rstOutN", 64'(out_n), 64'd0);
    checkOutput("rstOutTag", 64'(out_tag), 64'd0);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstInReady", 64'(in_ready), 64'd1);

    $display("[TB] directed vectors");
    applyStimulus(32'h0000_0000, 4'd3, 32'h0000_8000, 1'b1);
    applyStimulus(32'h0001_0000, 4'd1, 32'h0000_D762, 1'b1);
    applyStimulus(32'hFFFF_0000, 4'd2, 32'h0000_289E, 1'b1);
    applyStimulus(32'h0000_0800, 4'd4, 32'h0000_8330, 1'b1);
    applyStimulus(32'h0004_0000, 4'd5, 32'h0001_0000, 1'b1);
    applyStimulus(32'hFFFC_0000, 4'd6, 32'h0000_0000, 1'b1);
    applyStimulus(32'h8000_0000, 4'd7, 32'h0000_0000, 1'b1);
    applyStimulus(32'h7FFF_FFFF, 4'd8, 32'h0001_0000, 1'b1);
    waitDrain("drainDirected");
    checkOutput("idleBusy", 64'(busy), 64'd0);

    $display("[TB] random backpressure");
    randReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) rx = $urandom();
      else rx = 32'($urandom_range(0, 655360)) - 32'd327680;
      applyStimulus(rx, 4'(i), modelN(rx), 1'b0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    waitDrain("drainBackpressure");

    $display("[TB] reset with words in flight");
    applyStimulus(32'h0000_4000, 4'd9, 32'h0, 1'b0);
    applyStimulus(32'hFFFE_8000, 4'd10, 32'h0, 1'b0);
    applyStimulus(32'h0002_2000, 4'd11, 32'h0, 1'b0);
    reset = 1'b1;
    sbQueue.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midRstOutValid", 64'(out_valid), 64'd0);
    checkOutput("midRstBusy", 64'(busy), 64'd0);
    checkOutput("midRstInReady", 64'(in_ready), 64'd1);
    checkOutput("midRstOutN", 64'(out_n), 64'd0);
    applyStimulus(32'h0000_C000, 4'd12, modelN(32'h0000_C000), 1'b1);
    repeat (6) begin @(posedge clk); #1; end
    waitDrain("drainAfterReset");

    $display("[TB] sweep -4.5 .. +4.5");
    captureOn = 1'b1;
    for (int i = 0; i <= 9216; i++) begin
      rx = 32'(-294912 + 64 * i);
      applyStimulus(rx, 4'(i), modelN(rx), 1'b0);
    end
    waitDrain("drainSweep");
    captureOn = 1'b0;

    tolViol = 0; monoViol = 0; symViol = 0;
    checkOutput("sweepCount", 64'(sweepOut.size()), 64'd9217);
    if (sweepOut.size() == 9217) begin
      for (int i = 0; i <= 9216; i++) begin
        xr  = (-294912.0 + 64.0 * i) / 65536.0;
        err = $itor(sweepOut[i]) - phiRef(xr) * 65536.0;
        if (err > 40.0 || err < -40.0) tolViol++;
        if (i > 0 && sweepOut[i] < sweepOut[i - 1]) monoViol++;
        if (sweepOut[i] + sweepOut[9216 - i] != 65536) symViol++;
      end
    end
    checkOutput("sweepTolerance", 64'(tolViol), 64'd0);
    checkOutput("sweepMonotone", 64'(monoViol), 64'd0);
    checkOutput("sweepSymmetry", 64'(symViol), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
